sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_arb_rr2.sv | 35 +++
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic       PORT0    = 1'b0;
  localparam logic       PORT1    = 1'b1;
  localparam logic [3:0] MASK_ALL = 4'hF;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way grant: round-robin on the last-served port, or port 0 wins when fixed_prio.
// Grant is combinational from req; the pointer moves only when a grant is accepted.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  logic last;

  // Reset to port 1 as last served so port 0 is preferred first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT1;
    end else if (accept) begin
      last <= grant[1] ? PORT1 : PORT0;
    end
  end

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (fixed_prio || (last == PORT1)) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for a 1-cycle-latency byte-masked SRAM; read data returns 1 cycle after accept.
// Optional post-reset zero-fill of the whole array when SRAM_ARB_INIT_EN is defined.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_valid_i,
  output logic              p0_ready_o,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  input  logic [3:0]        p0_mask_i,
  output logic              p0_rvalid_o,
  output logic [31:0]       p0_rdata_o,
  input  logic              p1_valid_i,
  output logic              p1_ready_o,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  input  logic [3:0]        p1_mask_i,
  output logic              p1_rvalid_o,
  output logic [31:0]       p1_rdata_o,
  output logic              sram_cs_o,
  output logic              sram_wren_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  output logic [3:0]        sram_mask_o,
  input  logic [31:0]       sram_data_i,
  output logic              init_done_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              run;
  logic              xfer;
  logic              sel;
  logic              init_wr;
  logic [ADDR_W-1:0] init_addr;
  logic              rd_pend;
  logic              rd_port;

  // No access may leave the block in a cycle where reset is asserted.
  assign run  = (state == ST_RUN) && !rst_i;
  assign req  = {p1_valid_i, p0_valid_i};
  assign sel  = grant[1] ? PORT1 : PORT0;

  assign p0_ready_o = run && grant[0];
  assign p1_ready_o = run && grant[1];
  assign xfer       = (p0_valid_i && p0_ready_o) || (p1_valid_i && p1_ready_o);

  sram_arb_rr2 u_rr2 (
    .clk        (clk_i),
    .rst        (rst_i),
    .req        (req),
    .accept     (xfer),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (grant)
  );

`ifdef SRAM_ARB_INIT_EN
  state_e            state_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == (ADDR_W+1)'(DEPTH - 1)) begin
        state_nxt = ST_RUN;
      end
    end
  end

  assign init_done_o = (state == ST_RUN);
  assign init_wr     = (state == ST_INIT) && !rst_i;
  assign init_addr   = cnt[ADDR_W-1:0];
`else
  assign state       = ST_RUN;
  assign init_done_o = 1'b1;
  assign init_wr     = 1'b0;
  assign init_addr   = '0;
`endif

  always_comb begin
    sram_cs_o   = 1'b0;
    sram_wren_o = 1'b0;
    sram_addr_o = '0;
    sram_data_o = '0;
    sram_mask_o = '0;
    if (init_wr) begin
      sram_cs_o   = 1'b1;
      sram_wren_o = 1'b1;
      sram_addr_o = init_addr;
      sram_mask_o = MASK_ALL;
    end else if (xfer) begin
      sram_cs_o = 1'b1;
      if (sel == PORT1) begin
        sram_wren_o = p1_we_i;
        sram_addr_o = p1_addr_i;
        sram_data_o = p1_wdata_i;
        sram_mask_o = p1_mask_i;
      end else begin
        sram_wren_o = p0_we_i;
        sram_addr_o = p0_addr_i;
        sram_data_o = p0_wdata_i;
        sram_mask_o = p0_mask_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend <= 1'b0;
      rd_port <= PORT0;
    end else begin
      rd_pend <= xfer && !sram_wren_o;
      rd_port <= sel;
    end
  end

  // Gating with rst_i drops a response whose read was accepted just before reset.
  assign p0_rvalid_o = rd_pend && (rd_port == PORT0) && !rst_i;
  assign p1_rvalid_o = rd_pend && (rd_port == PORT1) && !rst_i;
  assign p0_rdata_o  = p0_rvalid_o ? sram_data_i : 32'h0;
  assign p1_rdata_o  = p1_rvalid_o ? sram_data_i : 32'h0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance 0 round-robin, instance 1 fixed priority, each with a behavioural SRAM.
module tb_sram_arbiter;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        inst;
    logic        port;
    logic [31:0] cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          vld  [2][2];
  logic          we   [2][2];
  logic          rdy  [2][2];
  logic          rv   [2][2];
  logic [AW-1:0] addr [2][2];
  logic [31:0]   wdat [2][2];
  logic [31:0]   rd   [2][2];
  logic [3:0]    msk  [2][2];
  logic          cs   [2];
  logic          wr   [2];
  logic          done [2];
  logic [AW-1:0] sa   [2];
  logic [31:0]   sd   [2];
  logic [3:0]    sm   [2];

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t        sb [$];
  int          gl0 [$];
  int          gl1 [$];
  bit          in_init [2];
  int          ic  [2];
  int          rvc [2][2];
  logic [31:0] refm [2][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [DEPTH];
    logic [31:0] rdq;

    sram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(g)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .p0_valid_i  (vld[g][0]),
      .p0_ready_o  (rdy[g][0]),
      .p0_we_i     (we[g][0]),
      .p0_addr_i   (addr[g][0]),
      .p0_wdata_i  (wdat[g][0]),
      .p0_mask_i   (msk[g][0]),
      .p0_rvalid_o (rv[g][0]),
      .p0_rdata_o  (rd[g][0]),
      .p1_valid_i  (vld[g][1]),
      .p1_ready_o  (rdy[g][1]),
      .p1_we_i     (we[g][1]),
      .p1_addr_i   (addr[g][1]),
      .p1_wdata_i  (wdat[g][1]),
      .p1_mask_i   (msk[g][1]),
      .p1_rvalid_o (rv[g][1]),
      .p1_rdata_o  (rd[g][1]),
      .sram_cs_o   (cs[g]),
      .sram_wren_o (wr[g]),
      .sram_addr_o (sa[g]),
      .sram_data_o (sd[g]),
      .sram_mask_o (sm[g]),
      .sram_data_i (rdq),
      .init_done_o (done[g])
    );

    always @(posedge clk) begin
      if (cs[g]) begin
        if (wr[g]) begin
          for (int b = 0; b < 4; b++)
            if (sm[g][b]) mem[sa[g]][8*b +: 8] <= sd[g][8*b +: 8];
        end else begin
          rdq <= mem[sa[g]];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pushes expected reads on accept, pops them on rvalid.
  always @(negedge clk) begin
    int   f;
    bit   x;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = sb.size() - 1; k >= 0; k--)
          if (sb[k].inst == 1'(i)) sb.delete(k);
        chk("rst_rv0", rv[i][0], 0);
        chk("rst_rv1", rv[i][1], 0);
        chk("rst_cs", cs[i], 0);
        in_init[i] = INIT_EN;
        ic[i] = 0;
      end else begin
        f = -1;
        for (int k = 0; k < sb.size(); k++)
          if (sb[k].inst == 1'(i) && sb[k].cyc == 32'(cyc)) f = k;
        if (f >= 0) begin
          e = sb[f];
          sb.delete(f);
          chk("rv_own", rv[i][e.port], 1);
          chk("rd_own", rd[i][e.port], e.data);
          chk("rv_other", rv[i][e.port ? 0 : 1], 0);
          chk("rd_other", rd[i][e.port ? 0 : 1], 0);
          if (rv[i][e.port]) rvc[i][e.port]++;
        end else if (rv[i][0] || rv[i][1]) begin
          chk("rv_spurious", {rv[i][1], rv[i][0]}, 0);
        end
        if (in_init[i]) begin
          chk("init_cs", {cs[i], wr[i]}, 2'b11);
          chk("init_addr", sa[i], ic[i]);
          chk("init_data", sd[i], 0);
          chk("init_mask", sm[i], 4'hF);
          chk("init_rdy", {rdy[i][1], rdy[i][0], done[i]}, 0);
          refm[i][ic[i]] = 32'h0;
          ic[i]++;
          if (ic[i] == DEPTH) in_init[i] = 1'b0;
        end else begin
          x = 1'b0;
          if (rdy[i][0] && rdy[i][1]) chk("rdy_both", {rdy[i][1], rdy[i][0]}, 2'b01);
          for (int p = 0; p < 2; p++) begin
            if (vld[i][p] && rdy[i][p]) begin
              x = 1'b1;
              if (i == 0) gl0.push_back(cyc * 2 + p);
              else        gl1.push_back(cyc * 2 + p);
              chk("bus_cs", cs[i], 1);
              chk("bus_we", wr[i], we[i][p]);
              chk("bus_addr", sa[i], addr[i][p]);
              if (we[i][p]) begin
                chk("bus_data", sd[i], wdat[i][p]);
                chk("bus_mask", sm[i], msk[i][p]);
                for (int b = 0; b < 4; b++)
                  if (msk[i][p][b]) refm[i][addr[i][p]][8*b +: 8] = wdat[i][p][8*b +: 8];
              end else begin
                e.inst = 1'(i);
                e.port = 1'(p);
                e.cyc  = 32'(cyc + 1);
                e.data = refm[i][addr[i][p]];
                sb.push_back(e);
              end
            end
          end
          if (!x) chk("idle_cs", cs[i], 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input int p, input logic w, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    bit ok = 1'b0;
    vld[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wdat[i][p] = d; msk[i][p] = m;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      ok = rdy[i][p];
    end
    chk("req_accept", ok, 1);
    tick();
    vld[i][p] = 1'b0;
  endtask

  task automatic both_read(input int i, input int n0, input int n1);
    fork
      begin
        for (int k = 0; k < n0; k++) req(i, 0, 1'b0, AW'(32'h100 + k % 4), 32'h0, 4'h0);
      end
      begin
        for (int k = 0; k < n1; k++) req(i, 1, 1'b0, AW'(32'h200 + k % 4), 32'h0, 4'h0);
      end
    join
  endtask

  task automatic check_rst(input int i, input bit bus);
    chk("rst_rdy0", rdy[i][0], 0);
    chk("rst_rdy1", rdy[i][1], 0);
    chk("rst_rvalid", {rv[i][1], rv[i][0]}, 0);
    chk("rst_rdata", {rd[i][1], rd[i][0]}, 0);
    if (bus) begin
      chk("rst_bus_ctl", {cs[i], wr[i]}, 0);
      chk("rst_bus_addr", sa[i], 0);
      chk("rst_bus_data", sd[i], 0);
      chk("rst_bus_mask", sm[i], 0);
    end
    chk("rst_done", done[i], !INIT_EN);
  endtask

  task automatic wait_init(input int seen);
`ifdef SRAM_ARB_INIT_EN
    int c = seen;
    while (!(done[0] && done[1]) && c < DEPTH + 20) begin
      @(negedge clk);
      c++;
    end
    chk("init_len", c, DEPTH + 1);
`endif
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, r0, r1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        vld[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdat[i][p] = '0; msk[i][p] = '0;
      end
    vld[0][0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst(0, 1'b1);
    check_rst(1, 1'b1);
    tick();
    vld[0][0] = 1'b0;
    rst = 1'b0;
    wait_init(0);

    // Full write then read on port 0.
    req(0, 0, 1'b1, AW'(5), 32'hDEADBEEF, 4'hF);
    req(0, 0, 1'b0, AW'(5), 32'h0, 4'h0);
    @(negedge clk);
    chk("p0_rv", rv[0][0], 1);
    chk("p0_rd", rd[0][0], 32'hDEADBEEF);
    chk("p1_quiet", rv[0][1], 0);
    @(negedge clk);
    chk("p0_rv_pulse", rv[0][0], 0);
    tick();

    // Byte-masked overwrite on port 1.
    req(0, 1, 1'b1, AW'(32'hAA), 32'hFFFFFFFF, 4'hF);
    req(0, 1, 1'b1, AW'(32'hAA), 32'h11223344, 4'h5);
    req(0, 1, 1'b0, AW'(32'hAA), 32'h0, 4'h0);
    @(negedge clk);
    chk("p1_rv", rv[0][1], 1);
    chk("p1_masked", rd[0][1], 32'hFF22FF44);
    chk("p0_quiet", rv[0][0], 0);
    tick();

    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        req(i, 0, 1'b1, AW'(32'h100 + k), 32'hA0000000 + i * 256 + k, 4'hF);
        req(i, 1, 1'b1, AW'(32'h200 + k), 32'hB0000000 + i * 256 + k, 4'hF);
      end

    // Round-robin contention: strict alternation starting with port 0.
    s = gl0.size(); r0 = rvc[0][0]; r1 = rvc[0][1];
    both_read(0, 4, 4);
    @(negedge clk);
    tick();
    chk("rr_cnt", gl0.size() - s, 8);
    if (gl0.size() >= s + 8)
      for (int k = 0; k < 8; k++) begin
        chk("rr_port", gl0[s + k] % 2, k % 2);
        if (k > 0) chk("rr_b2b", gl0[s + k] / 2 - gl0[s + k - 1] / 2, 1);
      end
    chk("rr_rv0", rvc[0][0] - r0, 4);
    chk("rr_rv1", rvc[0][1] - r1, 4);

    // Fixed priority: port 1 waits until port 0 drops valid.
    s = gl1.size();
    both_read(1, 8, 1);
    @(negedge clk);
    tick();
    chk("fp_cnt", gl1.size() - s, 9);
    if (gl1.size() >= s + 9) begin
      for (int k = 0; k < 8; k++) chk("fp_port0", gl1[s + k] % 2, 0);
      chk("fp_port1", gl1[s + 8] % 2, 1);
      chk("fp_p1_next_cycle", gl1[s + 8] / 2 - gl1[s + 7] / 2, 1);
    end

    // Reset right after a read accept drops the response.
    req(0, 0, 1'b0, AW'(5), 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_rv", rv[0][0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_rst(0, !INIT_EN);
    wait_init(1);

    // Pointer prefers port 0 after reset.
    s = gl0.size();
    both_read(0, 2, 2);
    @(negedge clk);
    tick();
    chk("ptr_cnt", gl0.size() - s, 4);
    if (gl0.size() >= s + 2) begin
      chk("ptr_first", gl0[s] % 2, 0);
      chk("ptr_second", gl0[s + 1] % 2, 1);
    end

`ifdef SRAM_ARB_INIT_EN
    req(0, 0, 1'b0, AW'(9), 32'h0, 4'h0);
    @(negedge clk);
    chk("init_rd9_rv", rv[0][0], 1);
    chk("init_rd9", rd[0][0], 32'h0);
    tick();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
